// File: rtl/fmq_cmd_encoder.sv
// Host-side encoder for the array board's 3-byte UART command frame.
// Latches a command, streams its framed bytes to the UART transmitter and,
// for query-type ops, waits for a single reply byte or times out.
module fmq_cmd_encoder #(
  parameter int unsigned CHANNELS     = 88,
  parameter int unsigned RESP_TIMEOUT = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  cmd_op,
  input  logic [6:0]  cmd_channel,
  input  logic [11:0] cmd_offset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  resp_data,
  output logic        resp_valid,
  output logic        resp_timeout,
  output logic        cmd_err,
  output logic        stray_rx,
  output logic        busy
);

  localparam int unsigned TimerW = $clog2(RESP_TIMEOUT);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(RESP_TIMEOUT - 1);
  localparam logic [TimerW-1:0] TimerMax  = '1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSend0 = 3'd1;
  localparam logic [2:0] StSend1 = 3'd2;
  localparam logic [2:0] StSend2 = 3'd3;
  localparam logic [2:0] StWait  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [7:0]        byte0_q, byte0_d;
  logic [7:0]        byte1_q, byte1_d;
  logic [7:0]        byte2_q, byte2_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [7:0]        resp_data_q, resp_data_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_timeout_q, resp_timeout_d;
  logic              cmd_err_q, cmd_err_d;
  logic              stray_rx_q, stray_rx_d;
  // Low only in the cycle(s) following a reset edge; gates both ready outputs.
  logic              live_q;

  logic [6:0]  ch_eff;
  logic [11:0] off_eff;
  logic        accept;
  logic        tx_fire;
  logic        rx_fire;

  assign cmd_ready    = live_q && (state_q == StIdle);
  assign rx_ready     = live_q;
  assign busy         = (state_q != StIdle);
  assign resp_data    = resp_data_q;
  assign resp_valid   = resp_valid_q;
  assign resp_timeout = resp_timeout_q;
  assign cmd_err      = cmd_err_q;
  assign stray_rx     = stray_rx_q;

  assign accept  = cmd_valid && cmd_ready;
  assign tx_fire = tx_valid && tx_ready;
  assign rx_fire = rx_valid && rx_ready;

  // Only set-offset carries channel/offset; other ops encode them as zero.
  assign ch_eff  = (cmd_op == 2'b00) ? cmd_channel : 7'd0;
  assign off_eff = (cmd_op == 2'b00) ? cmd_offset : 12'd0;

  // Byte-stream outputs are decoded from the current send state.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    unique case (state_q)
      StSend0: begin tx_valid = 1'b1; tx_data = byte0_q; end
      StSend1: begin tx_valid = 1'b1; tx_data = byte1_q; end
      StSend2: begin tx_valid = 1'b1; tx_data = byte2_q; end
      default: ;
    endcase
  end

  // Next-state, frame latch, reply timer and pulse generation.
  always_comb begin
    state_d        = state_q;
    byte0_d        = byte0_q;
    byte1_d        = byte1_q;
    byte2_d        = byte2_q;
    timer_d        = timer_q;
    resp_data_d    = resp_data_q;
    resp_valid_d   = 1'b0;
    resp_timeout_d = 1'b0;
    cmd_err_d      = 1'b0;
    stray_rx_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          byte0_d = {1'b1, cmd_op, ch_eff[6:2]};
          byte1_d = {1'b0, ch_eff[1:0], off_eff[11:7]};
          byte2_d = {1'b0, off_eff[6:0]};
          if ((cmd_op == 2'b00) && (32'(cmd_channel) >= CHANNELS)) begin
            cmd_err_d = 1'b1;
          end else begin
            state_d = StSend0;
          end
        end
      end
      StSend0: if (tx_fire) state_d = StSend1;
      StSend1: if (tx_fire) state_d = StSend2;
      StSend2: begin
        if (tx_fire) begin
          // op[1] set (query / reserved) means a reply byte is expected.
          state_d = byte0_q[6] ? StWait : StIdle;
          timer_d = '0;
        end
      end
      StWait: begin
        // A reply on the expiry cycle takes priority over the timeout.
        if (rx_fire) begin
          resp_data_d  = rx_data;
          resp_valid_d = 1'b1;
          state_d      = StIdle;
        end else if (timer_q == TimerLast) begin
          resp_timeout_d = 1'b1;
          state_d        = StIdle;
        end else if (timer_q != TimerMax) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (rx_fire && (state_q != StWait)) begin
      stray_rx_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= StIdle;
      byte0_q        <= 8'h00;
      byte1_q        <= 8'h00;
      byte2_q        <= 8'h00;
      timer_q        <= '0;
      resp_data_q    <= 8'h00;
      resp_valid_q   <= 1'b0;
      resp_timeout_q <= 1'b0;
      cmd_err_q      <= 1'b0;
      stray_rx_q     <= 1'b0;
      live_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte0_q        <= byte0_d;
      byte1_q        <= byte1_d;
      byte2_q        <= byte2_d;
      timer_q        <= timer_d;
      resp_data_q    <= resp_data_d;
      resp_valid_q   <= resp_valid_d;
      resp_timeout_q <= resp_timeout_d;
      cmd_err_q      <= cmd_err_d;
      stray_rx_q     <= stray_rx_d;
      live_q         <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fmq_cmd_encoder.sv
// Self-checking bench for fmq_cmd_encoder: directed scenarios plus a
// randomized run scored against an arithmetic model of the frame format.
module tb_fmq_cmd_encoder;

  localparam int unsigned CH = 88;
  localparam int unsigned TO = 512;

  logic        clk;
  logic        rst;
  logic [1:0]  cmd_op;
  logic [6:0]  cmd_channel;
  logic [11:0] cmd_offset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  resp_data;
  logic        resp_valid;
  logic        resp_timeout;
  logic        cmd_err;
  logic        stray_rx;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_resp = 8'h00;

  fmq_cmd_encoder #(
    .CHANNELS    (CH),
    .RESP_TIMEOUT(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_op      (cmd_op),
    .cmd_channel (cmd_channel),
    .cmd_offset  (cmd_offset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .resp_data   (resp_data),
    .resp_valid  (resp_valid),
    .resp_timeout(resp_timeout),
    .cmd_err     (cmd_err),
    .stray_rx    (stray_rx),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Reference frame: marker bit, then 5+2 channel bits, then 5+7 offset bits.
  function automatic logic [23:0] encode(int op, int ch, int off);
    int b0, b1, b2;
    if (op != 0) begin
      ch  = 0;
      off = 0;
    end
    b0 = 128 + op * 32 + ch / 4;
    b1 = (ch % 4) * 32 + off / 128;
    b2 = off % 128;
    return {b0[7:0], b1[7:0], b2[7:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input int op, input int ch, input int off);
    cmd_op      = 2'(op);
    cmd_channel = 7'(ch);
    cmd_offset  = 12'(off);
    cmd_valid   = 1'b1;
    tick();
    cmd_valid   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({tx_valid, tx_data, resp_data, resp_valid, resp_timeout, cmd_err, stray_rx, busy,
         cmd_ready, rx_ready} !== 25'h0)
      $display("FAIL reset_outputs: got %b %h %h %b%b%b%b%b%b%b want all zero", tx_valid,
               tx_data, resp_data, resp_valid, resp_timeout, cmd_err, stray_rx, busy,
               cmd_ready, rx_ready);
    else n_pass++;
    rst = 1'b1;
    tick();
    n_checks++;
    if ({cmd_ready, rx_ready, busy} !== 3'b110)
      $display("FAIL reset_release: got %b want 110", {cmd_ready, rx_ready, busy});
    else n_pass++;
  endtask

  task automatic test_set_offset;
    logic [23:0] f = 24'h95353C;
    start_cmd(0, 85, 'hABC);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({tx_valid, busy, tx_data} !== {2'b11, f[23-8*i -: 8]})
        $display("FAIL set_byte%0d: got %b%b %h want 11 %h", i, tx_valid, busy, tx_data,
                 f[23-8*i -: 8]);
      else n_pass++;
      tick();
    end
    n_checks++;
    if ({busy, cmd_ready, tx_valid} !== 3'b010)
      $display("FAIL set_idle: got %b want 010", {busy, cmd_ready, tx_valid});
    else n_pass++;
  endtask

  task automatic test_reload;
    logic [23:0] f = 24'hA00000;
    start_cmd(1, 'h7F, 'hFFF);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({tx_valid, tx_data} !== {1'b1, f[23-8*i -: 8]})
        $display("FAIL reload_byte%0d: got %b %h want 1 %h", i, tx_valid, tx_data,
                 f[23-8*i -: 8]);
      else n_pass++;
      tick();
    end
    n_checks++;
    if ({cmd_ready, busy} !== 2'b10)
      $display("FAIL reload_ready: got %b want 10", {cmd_ready, busy});
    else n_pass++;
  endtask

  task automatic test_query(input int op, input logic [23:0] f, input logic [7:0] reply);
    logic bad = 1'b0;
    start_cmd(op, 'h55, 'h123);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({tx_valid, tx_data} !== {1'b1, f[23-8*i -: 8]})
        $display("FAIL query%0d_byte%0d: got %b %h want 1 %h", op, i, tx_valid, tx_data,
                 f[23-8*i -: 8]);
      else n_pass++;
      tick();
    end
    for (int k = 1; k < 100; k++) begin
      if (resp_valid || resp_timeout || !busy || tx_valid) bad = 1'b1;
      tick();
    end
    n_checks++;
    if (bad !== 1'b0) $display("FAIL query%0d_wait: got early event want quiet wait", op);
    else n_pass++;
    rx_valid = 1'b1;
    rx_data  = reply;
    tick();
    rx_valid = 1'b0;
    exp_resp = reply;
    n_checks++;
    if ({resp_valid, resp_timeout, cmd_ready, resp_data} !== {3'b101, reply})
      $display("FAIL query%0d_reply: got %b%b%b %h want 101 %h", op, resp_valid, resp_timeout,
               cmd_ready, resp_data, reply);
    else n_pass++;
    tick();
    n_checks++;
    if ({resp_valid, resp_timeout, stray_rx} !== 3'b000)
      $display("FAIL query%0d_pulse: got %b want 000", op, {resp_valid, resp_timeout, stray_rx});
    else n_pass++;
  endtask

  task automatic test_timeout;
    logic early = 1'b0;
    start_cmd(2, 0, 0);
    repeat (3) tick();
    for (int k = 1; k <= int'(TO); k++) begin
      tick();
      if (k < int'(TO) && resp_timeout) early = 1'b1;
    end
    n_checks++;
    if ({early, resp_timeout, resp_valid, cmd_ready, resp_data} !== {4'b0101, exp_resp})
      $display("FAIL timeout_pulse: got early=%b to=%b rv=%b rdy=%b %h want 0 1 0 1 %h", early,
               resp_timeout, resp_valid, cmd_ready, resp_data, exp_resp);
    else n_pass++;
    tick();
    n_checks++;
    if (resp_timeout !== 1'b0) $display("FAIL timeout_width: got %b want 0", resp_timeout);
    else n_pass++;
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    tick();
    rx_valid = 1'b0;
    n_checks++;
    if ({stray_rx, resp_valid, resp_data} !== {2'b10, exp_resp})
      $display("FAIL timeout_stray: got %b%b %h want 10 %h", stray_rx, resp_valid, resp_data,
               exp_resp);
    else n_pass++;
    tick();
    n_checks++;
    if (stray_rx !== 1'b0) $display("FAIL stray_width: got %b want 0", stray_rx);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    logic bad = 1'b0;
    start_cmd(0, 85, 'hABC);
    tick();
    tx_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if ({tx_valid, tx_data} !== 9'h135) bad = 1'b1;
      tick();
    end
    n_checks++;
    if ({bad, tx_valid, tx_data} !== 10'h135)
      $display("FAIL bp_hold: got bad=%b %b %h want 0 1 35", bad, tx_valid, tx_data);
    else n_pass++;
    tx_ready = 1'b1;
    tick();
    n_checks++;
    if ({tx_valid, tx_data} !== 9'h13C)
      $display("FAIL bp_byte2: got %b %h want 1 3c", tx_valid, tx_data);
    else n_pass++;
    tick();
    n_checks++;
    if ({cmd_ready, busy} !== 2'b10) $display("FAIL bp_idle: got %b want 10", {cmd_ready, busy});
    else n_pass++;
  endtask

  task automatic test_reply_on_timeout;
    start_cmd(2, 0, 0);
    repeat (3) tick();
    repeat (TO - 1) tick();
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    tick();
    rx_valid = 1'b0;
    exp_resp = 8'hA5;
    n_checks++;
    if ({resp_valid, resp_timeout, resp_data} !== {2'b10, 8'hA5})
      $display("FAIL race_reply: got %b%b %h want 10 a5", resp_valid, resp_timeout, resp_data);
    else n_pass++;
    tick();
    n_checks++;
    if ({resp_valid, resp_timeout} !== 2'b00)
      $display("FAIL race_after: got %b want 00", {resp_valid, resp_timeout});
    else n_pass++;
  endtask

  task automatic test_reject;
    start_cmd(0, 88, 'h123);
    n_checks++;
    if ({cmd_err, tx_valid, busy, cmd_ready} !== 4'b1001)
      $display("FAIL reject: got %b want 1001", {cmd_err, tx_valid, busy, cmd_ready});
    else n_pass++;
    tick();
    n_checks++;
    if ({cmd_err, tx_valid, busy} !== 3'b000)
      $display("FAIL reject_after: got %b want 000", {cmd_err, tx_valid, busy});
    else n_pass++;
  endtask

  task automatic test_reset_midframe;
    logic [23:0] f = 24'h806101;
    start_cmd(0, 85, 'hABC);
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({tx_valid, busy, cmd_ready, rx_ready} !== 4'b0000)
      $display("FAIL midreset: got %b want 0000", {tx_valid, busy, cmd_ready, rx_ready});
    else n_pass++;
    rst = 1'b1;
    tick();
    start_cmd(0, 3, 'h081);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({tx_valid, tx_data} !== {1'b1, f[23-8*i -: 8]})
        $display("FAIL postreset_byte%0d: got %b %h want 1 %h", i, tx_valid, tx_data,
                 f[23-8*i -: 8]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_random;
    logic [23:0] f;
    logic [7:0]  r;
    int op, ch, off, d;
    for (int it = 0; it < 30; it++) begin
      op  = int'($urandom_range(0, 3));
      ch  = int'($urandom_range(0, 127));
      off = int'($urandom_range(0, 4095));
      n_checks++;
      if (cmd_ready !== 1'b1) $display("FAIL rnd%0d_ready: got %b want 1", it, cmd_ready);
      else n_pass++;
      start_cmd(op, ch, off);
      if (op == 0 && ch >= int'(CH)) begin
        n_checks++;
        if ({cmd_err, tx_valid} !== 2'b10)
          $display("FAIL rnd%0d_reject: got %b want 10", it, {cmd_err, tx_valid});
        else n_pass++;
        tick();
        continue;
      end
      f = encode(op, ch, off);
      for (int i = 0; i < 3; i++) begin
        for (int w = 0; w < 40; w++) begin
          tx_ready = (w >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
          n_checks++;
          if ({tx_valid, tx_data} !== {1'b1, f[23-8*i -: 8]})
            $display("FAIL rnd%0d_byte%0d: got %b %h want 1 %h", it, i, tx_valid, tx_data,
                     f[23-8*i -: 8]);
          else n_pass++;
          tick();
          if (tx_ready) break;
        end
      end
      tx_ready = 1'b1;
      if (op >= 2) begin
        if ($urandom_range(0, 7) == 0) begin
          repeat (TO) tick();
          n_checks++;
          if ({resp_timeout, resp_valid, resp_data} !== {2'b10, exp_resp})
            $display("FAIL rnd%0d_timeout: got %b%b %h want 10 %h", it, resp_timeout,
                     resp_valid, resp_data, exp_resp);
          else n_pass++;
        end else begin
          d = int'($urandom_range(1, 60));
          repeat (d - 1) tick();
          r = 8'($urandom);
          rx_valid = 1'b1;
          rx_data  = r;
          tick();
          rx_valid = 1'b0;
          exp_resp = r;
          n_checks++;
          if ({resp_valid, resp_timeout, resp_data} !== {2'b10, r})
            $display("FAIL rnd%0d_reply: got %b%b %h want 10 %h", it, resp_valid, resp_timeout,
                     resp_data, r);
          else n_pass++;
        end
      end else begin
        n_checks++;
        if ({cmd_ready, busy} !== 2'b10)
          $display("FAIL rnd%0d_idle: got %b want 10", it, {cmd_ready, busy});
        else n_pass++;
      end
      if ($urandom_range(0, 3) == 0) begin
        rx_valid = 1'b1;
        rx_data  = 8'($urandom);
        tick();
        rx_valid = 1'b0;
        n_checks++;
        if ({stray_rx, resp_valid} !== 2'b10)
          $display("FAIL rnd%0d_stray: got %b want 10", it, {stray_rx, resp_valid});
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst         = 1'b0;
    cmd_op      = 2'b00;
    cmd_channel = 7'd0;
    cmd_offset  = 12'd0;
    cmd_valid   = 1'b0;
    tx_ready    = 1'b1;
    rx_data     = 8'h00;
    rx_valid    = 1'b0;
    test_reset();
    test_set_offset();
    test_reload();
    test_query(2, 24'hC00000, 8'h58);
    test_query(3, 24'hE00000, 8'h00);
    test_timeout();
    test_backpressure();
    test_reply_on_timeout();
    test_reject();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
